imul_varlat_nbit: RTL and testbench
===================================

Name: imul_varlat_nbit

Overview:
- Parametrised variable-latency iterative integer multiplier. Control FSM and datapath live in one block.
- Computes the low NBITS of a*b with a shift-add loop.
- Skips runs of zero bits in b, up to MAX_SHAMT bits per cycle.
- Carries a 1-bit domain tag from request to response. It sits behind val/rdy request/response channels, in place of the fixed 32-bit multiplier.

Parameters:
- NBITS, 32, operand and result width (>=2).
- MAX_SHAMT, 4, maximum zero-skip shift per cycle (1..NBITS).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_val  in  1  request valid.
- in_rdy  out  1  request ready.
- in_a  in  NBITS  multiplicand.
- in_b  in  NBITS  multiplier.
- in_sd  in  1  domain tag of request.
- out_val  out  1  response valid.
- out_rdy  in  1  response ready.
- out_result  out  NBITS  low NBITS of a*b.
- out_sd  out  1  tag latched with the request.

Behaviour:
- States: IDLE, CALC, DONE. Reset -> IDLE; result_reg=0, a_reg=0, b_reg=0, sd_reg=0.
- Reset values: in_rdy=1, out_val=0, out_result=0, out_sd=0.
- in_go = in_val&&in_rdy; out_go = out_val&&out_rdy.
- IDLE: in_rdy=1, out_val=0.
  - On in_go: a_reg<=in_a, b_reg<=in_b, sd_reg<=in_sd, result_reg<=0; next state CALC.
- CALC: in_rdy=0, out_val=0.
  - If b_reg==0: next state DONE; registers hold.
  - Else if b_reg[0]==1: result_reg<=result_reg+a_reg (mod 2^NBITS); a_reg<<=1; b_reg>>=1.
  - Else: sh=min(trailing_zeros(b_reg),MAX_SHAMT); a_reg<<=sh; b_reg>>=sh; result unchanged.
- DONE: out_val=1, in_rdy=0, out_result=result_reg, out_sd=sd_reg.
  - On out_go: next state IDLE. Otherwise hold; outputs stable while out_rdy=0.
- Outside DONE: out_result and out_sd are driven with the register values, but are meaningful only when out_val=1.
- No back-to-back overlap: one transaction in flight. in_rdy=0 in CALC and DONE.
- Latency, from the in_go edge to the first cycle with out_val=1:
  - (number of CALC iterations with b!=0) + 2.
  - b=0 gives latency 2.
  - Worst case b=all-ones gives NBITS+2.
- Overflow bits beyond NBITS are discarded; shifting a_reg left discards its MSBs.
- Trailing-zero count saturates at MAX_SHAMT; b_reg==0 never shifts.
- in_a/in_b/in_sd are sampled only on in_go; changes at other times have no effect.
- Reset asserted in any state returns to IDLE on the next edge. An in-flight result is dropped and no response is produced.
- in_val, out_rdy, in_rdy, out_val must never be X after reset; assertion checks enforce this.

Optional Feature:
- Macro: IMUL_LATENCY_COUNT_EN.
- Defined: adds output out_cycles, width clog2(NBITS+3).
  - Cleared on in_go; increments each CALC cycle.
  - Valid and held with out_val; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- NBITS=32, MAX_SHAMT=4. a=5, b=8, sd=1, out_rdy=1 -> out_val in the 4th cycle after in_go; result=40; out_sd=1; out_cycles=3.
- a=7, b=0 -> out_val 2 cycles after in_go; result=0; out_cycles=1.
- a=1, b=0xFFFFFFFF -> result=0xFFFFFFFF, latency 34. Then a=0x80000000, b=2 -> result=0 (overflow discarded).
- b=0x00010000 (16 trailing zeros), a=3 -> 4 skip cycles + 1 add + done check; result=0x00030000; out_cycles=6.
- out_rdy held 0 for 5 cycles in DONE -> out_val, result, sd stable; in_rdy=0; in_val pulses ignored. out_rdy=1 -> IDLE next cycle, in_rdy=1.
- reset asserted mid-CALC (a=3, b=0xF0) -> next cycle IDLE, in_rdy=1, out_val=0. A new request a=6, b=7 then completes with result=42.

Source files
------------

// File: rtl/imul_varlat_nbit.sv
// rtl/imul_varlat_nbit.sv - variable-latency shift-add multiplier with zero-skip and domain tag
// Optional macro IMUL_LATENCY_COUNT_EN adds the out_cycles CALC-cycle counter output.
module imul_varlat_nbit #(
  parameter int NBITS     = 32,
  parameter int MAX_SHAMT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic             in_sd,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_result,
  output logic             out_sd
`ifdef IMUL_LATENCY_COUNT_EN
  ,
  output logic [$clog2(NBITS+3)-1:0] out_cycles
`endif
);

  localparam int SW = $clog2(MAX_SHAMT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NBITS-1:0] a_reg;
  logic [NBITS-1:0] b_reg;
  logic [NBITS-1:0] result_reg;
  logic             sd_reg;
  logic [SW-1:0]    sh;
  logic             in_go;
  logic             out_go;

  assign in_go  = in_val && in_rdy;
  assign out_go = out_val && out_rdy;

  // State register; reset always lands in IDLE, dropping any in-flight work.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs; one transaction in flight at a time.
  always_comb begin
    state_next = state;
    in_rdy     = 1'b0;
    out_val    = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_go) state_next = CALC;
      end
      CALC: begin
        if (b_reg == '0) state_next = DONE;
      end
      DONE: begin
        out_val = 1'b1;
        if (out_go) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Trailing-zero count of b_reg, saturated at MAX_SHAMT; only used when b_reg[0]==0.
  always_comb begin
    logic found;
    sh    = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SHAMT; i++) begin
      if (!found) begin
        if (b_reg[i]) found = 1'b1;
        else          sh    = SW'(i + 1);
      end
    end
  end

  // Datapath: load on accept, then add-and-shift or skip zero runs until b_reg empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      sd_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_go) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            sd_reg     <= in_sd;
            result_reg <= '0;
          end
        end
        CALC: begin
          if (b_reg != '0) begin
            if (b_reg[0]) begin
              result_reg <= result_reg + a_reg;
              a_reg      <= a_reg << 1;
              b_reg      <= b_reg >> 1;
            end else begin
              a_reg <= a_reg << sh;
              b_reg <= b_reg >> sh;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = result_reg;
  assign out_sd     = sd_reg;

`ifdef IMUL_LATENCY_COUNT_EN
  // Counts CALC cycles of the current transaction; holds through DONE.
  always_ff @(posedge clk) begin
    if (reset)                      out_cycles <= '0;
    else if (state == IDLE && in_go) out_cycles <= '0;
    else if (state == CALC)         out_cycles <= out_cycles + 1'b1;
  end
`endif

  // Handshake signals must always be known once out of reset.
  a_no_x : assert property (@(posedge clk) disable iff (reset)
    !$isunknown({in_val, out_rdy, in_rdy, out_val}));

endmodule

// File: tb/tb_imul_varlat_nbit.sv
// tb/tb_imul_varlat_nbit.sv - self-checking bench for imul_varlat_nbit
module tb_imul_varlat_nbit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sd;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_result;
  logic        out_sd;
`ifdef IMUL_LATENCY_COUNT_EN
  logic [5:0]  out_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  imul_varlat_nbit #(.NBITS(32), .MAX_SHAMT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sd      (in_sd),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_result (out_result),
    .out_sd     (out_sd)
`ifdef IMUL_LATENCY_COUNT_EN
    ,
    .out_cycles (out_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: product mod 2^32, and latency from counting loop iterations on b.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  function automatic int ref_latency(input logic [31:0] b);
    int iters = 0;
    longint unsigned v = longint'(b);
    while (v != 0) begin
      if (v % 2 == 1) v = v / 2;
      else begin
        int tz = 0;
        while (tz < 4 && ((v >> tz) % 2 == 0)) tz++;
        v = v >> tz;
      end
      iters++;
    end
    return iters + 2;
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic sd,
                         output logic [31:0] res, output logic rsd, output int lat, output int cyc);
    @(negedge clk);
    in_a = a; in_b = b; in_sd = sd; in_val = 1'b1;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sd = ~sd;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_val) break;
    end
    if (!out_val) begin
      n_checks++; n_fail++;
      $display("FAIL txn_timeout: out_val=%0b after %0d cycles, required 1", out_val, lat);
    end
    res = out_result;
    rsd = out_sd;
`ifdef IMUL_LATENCY_COUNT_EN
    cyc = int'(out_cycles);
`else
    cyc = lat - 1;
`endif
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] res, a, b, hold_res;
    logic        rsd, sd;
    int          lat, cyc, waited;

    vecs[0] = '{a: 32'd5,          b: 32'd8,          sd: 1'b1, res: 32'd40,         lat: 4};
    vecs[1] = '{a: 32'd7,          b: 32'd0,          sd: 1'b0, res: 32'd0,          lat: 2};
    vecs[2] = '{a: 32'd1,          b: 32'hFFFF_FFFF,  sd: 1'b1, res: 32'hFFFF_FFFF,  lat: 34};
    vecs[3] = '{a: 32'h8000_0000,  b: 32'd2,          sd: 1'b0, res: 32'd0,          lat: 4};
    vecs[4] = '{a: 32'd3,          b: 32'h0001_0000,  sd: 1'b1, res: 32'h0003_0000,  lat: 7};
    vecs[5] = '{a: 32'd6,          b: 32'd7,          sd: 1'b0, res: 32'd42,         lat: 5};

    reset = 1'b1; in_val = 1'b0; in_a = '0; in_b = '0; in_sd = 1'b0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_in_rdy", 64'(in_rdy), 64'd1);
    check("reset_out_val", 64'(out_val), 64'd0);
    check("reset_out_result", 64'(out_result), 64'd0);
    check("reset_out_sd", 64'(out_sd), 64'd0);
`ifdef IMUL_LATENCY_COUNT_EN
    check("reset_out_cycles", 64'(out_cycles), 64'd0);
`endif

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].sd, res, rsd, lat, cyc);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
      check($sformatf("vec%0d_sd", i), 64'(rsd), 64'(vecs[i].sd));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
`ifdef IMUL_LATENCY_COUNT_EN
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].lat - 1));
`endif
    end

    // Randomised transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom & $urandom & $urandom;
        2: b = 32'd1 << $urandom_range(0, 31);
        default: b = 32'($urandom_range(0, 15));
      endcase
      sd = 1'($urandom_range(0, 1));
      run_txn(a, b, sd, res, rsd, lat, cyc);
      check($sformatf("rand%0d_result", i), 64'(res), 64'(ref_result(a, b)));
      check($sformatf("rand%0d_sd", i), 64'(rsd), 64'(sd));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_latency(b)));
`ifdef IMUL_LATENCY_COUNT_EN
      check($sformatf("rand%0d_cycles", i), 64'(cyc), 64'(ref_latency(b) - 1));
`endif
    end

    // Backpressure in DONE: outputs hold, requests ignored.
    @(negedge clk);
    out_rdy = 1'b0;
    in_a = 32'd9; in_b = 32'd3; in_sd = 1'b1; in_val = 1'b1;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    waited = 0;
    while (waited < 100 && !out_val) begin
      @(negedge clk);
      waited++;
    end
    check("stall_reached_done", 64'(out_val), 64'd1);
    hold_res = 32'd27;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_out_val", i), 64'(out_val), 64'd1);
      check($sformatf("stall%0d_result", i), 64'(out_result), 64'(hold_res));
      check($sformatf("stall%0d_sd", i), 64'(out_sd), 64'd1);
      check($sformatf("stall%0d_in_rdy", i), 64'(in_rdy), 64'd0);
      in_val = ~in_val; in_a = $urandom; in_b = $urandom; in_sd = 1'b0;
      @(negedge clk);
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    check("stall_release_in_rdy", 64'(in_rdy), 64'd1);
    check("stall_release_out_val", 64'(out_val), 64'd0);

    // Reset in the middle of CALC drops the transaction.
    @(negedge clk);
    in_a = 32'd3; in_b = 32'hF0; in_sd = 1'b1; in_val = 1'b1;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midcalc_busy", 64'(in_rdy), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_in_rdy", 64'(in_rdy), 64'd1);
    check("midreset_out_val", 64'(out_val), 64'd0);
    check("midreset_result", 64'(out_result), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midreset_no_resp%0d", i), 64'(out_val), 64'd0);
    end
    run_txn(32'd6, 32'd7, 1'b0, res, rsd, lat, cyc);
    check("after_reset_result", 64'(res), 64'd42);
    check("after_reset_latency", 64'(lat), 64'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
